h14tx_phy_start: RTL and testbench
==================================

H14TX_PHY_START -- requirements
Module: h14tx_phy_start

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before serializer bring-up.
REQ-002 SHALL have parameter SER_RST_CYCLES, default 16: serializer reset hold length.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 8: cycles after serializer reset release with outputs still disabled.
REQ-004 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65535: maximum WaitLock dwell before Fault.
REQ-005 SHALL have port clk, input, 1: pixel-domain clock.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low; driven by the upstream synchronized reset.
REQ-007 SHALL have port pll_lock, input, 1: TMDS PLL lock, asynchronous to clk.
REQ-008 SHALL have port restart, input, 1: single-cycle request to leave Fault.
REQ-009 SHALL have port ser_rst, output, 1: serializer reset, active-high.
REQ-010 SHALL have port tmds_oe, output, 1: TMDS output-driver enable.
REQ-011 SHALL have port video_en, output, 1: enables the upstream video/encoder pipeline.
REQ-012 SHALL have port ready, output, 1: link up.
REQ-013 SHALL have port fault, output, 1: lock timeout occurred.
REQ-014 SHALL have port lock_loss_cnt, output, 8: count of lock losses in Run; tied to 0 when the macro is off.

Function
REQ-015 SHALL synchronize pll_lock through a 2-FF synchronizer (pll_lock_s); no other logic SHALL use raw pll_lock.
REQ-016 SHALL implement FSM states WaitLock, Settle, SerReset, Flush, Run, Fault.
REQ-017 WaitLock SHALL go to Settle on the cycle after pll_lock_s=1, and to Fault once the dwell counter reaches LOCK_TIMEOUT_CYCLES-1 with pll_lock_s=0.
REQ-018 Settle SHALL count consecutive pll_lock_s=1 cycles, return to WaitLock on any pll_lock_s=0, and go to SerReset after exactly LOCK_STABLE_CYCLES cycles.
REQ-019 SerReset SHALL last exactly SER_RST_CYCLES cycles and then go to Flush.
REQ-020 Flush SHALL last exactly FLUSH_CYCLES cycles and then go to Run.
REQ-021 Fault SHALL go to WaitLock on restart=1; restart SHALL be ignored in all other states.
REQ-022 Outputs SHALL be a Moore decode of the state register: ser_rst=1 in WaitLock, Settle, SerReset and Fault; tmds_oe=video_en=ready=1 only in Run; fault=1 only in Fault.
REQ-023 A single shared down/up counter SHALL be used, width $clog2 of the largest parameter plus 1; it SHALL clear on every state change.
REQ-024 Lock-loss counter SHALL saturate at 255 and SHALL never wrap.
REQ-025 A pll_lock_s drop in the same cycle as a timed-state terminal count SHALL take the lock-drop transition where one is defined (Settle, and Run with the macro on).

Reset
REQ-026 rst_n low SHALL asynchronously force: state WaitLock, counter 0, synchronizer 0, lock_loss_cnt 0, ser_rst=1, tmds_oe=0, video_en=0, ready=0, fault=0.
REQ-027 rst_n assertion mid-operation, including Run, SHALL drop tmds_oe, video_en and ready immediately (asynchronously).

Configuration
REQ-028 Macro H14TX_PHY_LOCK_WATCH_EN defined: pll_lock_s=0 in Run SHALL return the FSM to WaitLock on the next edge and increment lock_loss_cnt.
REQ-029 Macro H14TX_PHY_LOCK_WATCH_EN undefined: Run SHALL be terminal until reset, pll_lock SHALL be ignored in Run, and lock_loss_cnt SHALL be constant 0 with no counter flops.

Structure
REQ-030 Enum phy_start_state_t SHALL reside in shared package h14tx_pkg.
REQ-031 The 2-FF synchronizer SHALL be sub-module h14tx_sync2 (async active-low reset, reset value 0).

Verification (LOCK_STABLE=4, SER_RST=3, FLUSH=2, TIMEOUT=20)
REQ-032 pll_lock=1 before rst_n release -> ready=1 exactly 12 clk edges after release (2 synchronizer + 1 + 4 + 3 + 2); ser_rst falls at edge 10.
REQ-033 pll_lock=0 throughout -> fault=1 after 22 edges with ser_rst=1; one-cycle restart -> fault=0 on the next edge.
REQ-034 pll_lock low for one cycle during Settle -> FSM returns to WaitLock and the full 4-cycle Settle restarts; ready is delayed accordingly.
REQ-035 Macro on, pll_lock drops in Run -> ready=0 three edges later and lock_loss_cnt=1; 300 drops -> lock_loss_cnt=255.
REQ-036 Macro off, pll_lock drops in Run -> ready stays 1; rst_n pulsed low in Run -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/h14tx_pkg.sv
// rtl/h14tx_pkg.sv - shared types and helpers for the h14tx PHY start-up block
package h14tx_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_SER_RESET = 3'd2,
    ST_FLUSH     = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } phy_start_state_t;

  typedef struct packed {
    logic ser_rst;
    logic tmds_oe;
    logic video_en;
    logic ready;
    logic fault;
  } phy_start_out_t;

  // Largest of four timing parameters; sizes the shared phase counter.
  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Moore output decode: the serializer stays in reset until Flush, link is only up in Run.
  function automatic phy_start_out_t decode_outputs(input phy_start_state_t s);
    phy_start_out_t o;
    o = '0;
    case (s)
      ST_WAIT_LOCK, ST_SETTLE, ST_SER_RESET: o.ser_rst = 1'b1;
      ST_FAULT: begin
        o.ser_rst = 1'b1;
        o.fault   = 1'b1;
      end
      ST_RUN: begin
        o.tmds_oe  = 1'b1;
        o.video_en = 1'b1;
        o.ready    = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/h14tx_sync2.sv
// rtl/h14tx_sync2.sv - two-flop synchronizer, async active-low reset to 0
module h14tx_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops resolve metastability on the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/h14tx_phy_start.sv
// rtl/h14tx_phy_start.sv - TMDS PHY start-up sequencer; optional lock watch via H14TX_PHY_LOCK_WATCH_EN
module h14tx_phy_start
  import h14tx_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int SER_RST_CYCLES      = 16,
  parameter int FLUSH_CYCLES        = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       ser_rst,
  output logic       tmds_oe,
  output logic       video_en,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_loss_cnt
);

  localparam int CNT_W = $clog2(max_of4(LOCK_STABLE_CYCLES, SER_RST_CYCLES,
                                        FLUSH_CYCLES, LOCK_TIMEOUT_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SER_RST_LAST = CNT_W'(SER_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST   = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  phy_start_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pll_lock_s;
  logic [1:0]       sync_warm;
  phy_start_out_t   out_nxt;

  h14tx_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (pll_lock_s)
  );

  // The synchronizer output only carries real information two edges after reset
  // release, so the WaitLock timeout window opens once this shifter fills.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_warm <= 2'b00;
    else        sync_warm <= {sync_warm[0], 1'b1};
  end

  // Next-state and shared phase counter; lock loss wins over any terminal count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    case (state)
      ST_WAIT_LOCK: begin
        if (pll_lock_s)                  state_nxt = ST_SETTLE;
        else if (!sync_warm[1])          cnt_nxt   = cnt;
        else if (cnt == TIMEOUT_LAST)    state_nxt = ST_FAULT;
      end
      ST_SETTLE: begin
        if (!pll_lock_s)                 state_nxt = ST_WAIT_LOCK;
        else if (cnt == STABLE_LAST)     state_nxt = ST_SER_RESET;
      end
      ST_SER_RESET: begin
        if (cnt == SER_RST_LAST)         state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (cnt == FLUSH_LAST)           state_nxt = ST_RUN;
      end
      ST_RUN: begin
        cnt_nxt = cnt;
`ifdef H14TX_PHY_LOCK_WATCH_EN
        if (!pll_lock_s)                 state_nxt = ST_WAIT_LOCK;
`endif
      end
      ST_FAULT: begin
        cnt_nxt = cnt;
        if (restart)                     state_nxt = ST_WAIT_LOCK;
      end
      default:                           state_nxt = ST_WAIT_LOCK;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
    out_nxt = decode_outputs(state_nxt);
  end

  // State, counter and registered Moore outputs; reset drops the link at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_WAIT_LOCK;
      cnt      <= '0;
      ser_rst  <= 1'b1;
      tmds_oe  <= 1'b0;
      video_en <= 1'b0;
      ready    <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ser_rst  <= out_nxt.ser_rst;
      tmds_oe  <= out_nxt.tmds_oe;
      video_en <= out_nxt.video_en;
      ready    <= out_nxt.ready;
      fault    <= out_nxt.fault;
    end
  end

`ifdef H14TX_PHY_LOCK_WATCH_EN
  logic [7:0] loss_q;

  // Count each Run exit caused by lock loss, saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= 8'd0;
    end else if (state == ST_RUN && !pll_lock_s && loss_q != 8'hFF) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_h14tx_phy_start.sv
// tb/tb_h14tx_phy_start.sv - directed, table-driven bench for h14tx_phy_start
module tb_h14tx_phy_start;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_lock = 1'b0;
  logic       restart = 1'b0;
  logic       ser_rst, tmds_oe, video_en, ready, fault;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  h14tx_phy_start #(
    .LOCK_STABLE_CYCLES  (4),
    .SER_RST_CYCLES      (3),
    .FLUSH_CYCLES        (2),
    .LOCK_TIMEOUT_CYCLES (20)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock      (pll_lock),
    .restart       (restart),
    .ser_rst       (ser_rst),
    .tmds_oe       (tmds_oe),
    .video_en      (video_en),
    .ready         (ready),
    .fault         (fault),
    .lock_loss_cnt (lock_loss_cnt)
  );

  // lock_init: pll_lock during/after reset; rise_at/drop_at: edge after which lock
  // goes high / goes low for one cycle (0 = unused); *_at: first edge of the event (0 = never).
  typedef struct {
    bit lock_init;
    int rise_at;
    int drop_at;
    int ser_fall;
    int ready_at;
    int fault_at;
  } scen_t;

  scen_t rows[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit lk);
    rst_n    = 1'b0;
    restart  = 1'b0;
    pll_lock = lk;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    ok = ready;
  endtask

  initial begin
    bit ok;
    bit exp_ser, exp_rdy, exp_flt;

    rows.push_back('{1'b1, 0, 0, 10, 12, 0});   // clean bring-up
    rows.push_back('{1'b0, 0, 0,  0,  0, 22});  // no lock -> timeout
    rows.push_back('{1'b1, 0, 4, 15, 17, 0});   // drop hits Settle terminal count
    rows.push_back('{1'b0, 5, 0, 15, 17, 0});   // lock arrives late
    rows.push_back('{1'b1, 0, 7, 10, 12, 0});   // drop during SerReset is ignored
`ifndef H14TX_PHY_LOCK_WATCH_EN
    rows.push_back('{1'b1, 0, 14, 10, 12, 0});  // drop in Run ignored
`endif

    // Asynchronous reset state, no clock edge required.
    #2 rst_n = 1'b0;
    #1;
    check("rst_ser_rst", int'(ser_rst), 1);
    check("rst_tmds_oe", int'(tmds_oe), 0);
    check("rst_video_en", int'(video_en), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_loss", int'(lock_loss_cnt), 0);

    for (int r = 0; r < rows.size(); r++) begin
      do_reset(rows[r].lock_init);
      for (int e = 1; e <= 30; e++) begin
        if (rows[r].rise_at != 0 && e - 1 == rows[r].rise_at) pll_lock = 1'b1;
        if (rows[r].drop_at != 0 && e - 1 == rows[r].drop_at) pll_lock = 1'b0;
        if (rows[r].drop_at != 0 && e - 1 == rows[r].drop_at + 1) pll_lock = 1'b1;
        step();
        exp_ser = !(rows[r].ser_fall != 0 && e >= rows[r].ser_fall);
        exp_rdy = (rows[r].ready_at != 0 && e >= rows[r].ready_at);
        exp_flt = (rows[r].fault_at != 0 && e >= rows[r].fault_at);
        check($sformatf("s%0d_e%0d_ser_rst", r, e), int'(ser_rst), int'(exp_ser));
        check($sformatf("s%0d_e%0d_ready", r, e), int'(ready), int'(exp_rdy));
        check($sformatf("s%0d_e%0d_tmds_oe", r, e), int'(tmds_oe), int'(exp_rdy));
        check($sformatf("s%0d_e%0d_video_en", r, e), int'(video_en), int'(exp_rdy));
        check($sformatf("s%0d_e%0d_fault", r, e), int'(fault), int'(exp_flt));
      end
    end

    // Fault then restart, then a second full timeout from WaitLock.
    do_reset(1'b0);
    for (int e = 0; e < 22; e++) step();
    check("flt_fault", int'(fault), 1);
    check("flt_ser_rst", int'(ser_rst), 1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart_fault", int'(fault), 0);
    check("restart_ser_rst", int'(ser_rst), 1);
    for (int e = 0; e < 19; e++) step();
    check("refault_e19", int'(fault), 0);
    step();
    check("refault_e20", int'(fault), 1);

    // Restart ignored in Run, then asynchronous reset mid-cycle.
    do_reset(1'b1);
    for (int e = 0; e < 12; e++) step();
    check("run_ready", int'(ready), 1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    step();
    check("run_restart_ignored", int'(ready), 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_ready", int'(ready), 0);
    check("async_tmds_oe", int'(tmds_oe), 0);
    check("async_video_en", int'(video_en), 0);
    check("async_ser_rst", int'(ser_rst), 1);
    check("async_fault", int'(fault), 0);

    // Lock drop in Run.
    do_reset(1'b1);
    for (int e = 0; e < 12; e++) step();
    check("drop_pre_ready", int'(ready), 1);
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    step();
`ifdef H14TX_PHY_LOCK_WATCH_EN
    check("drop_e2_ready", int'(ready), 1);
    step();
    check("drop_e3_ready", int'(ready), 0);
    check("drop_e3_ser_rst", int'(ser_rst), 1);
    check("drop_loss1", int'(lock_loss_cnt), 1);
    for (int i = 2; i <= 300; i++) begin
      wait_ready(ok);
      if (!ok) begin
        check($sformatf("relock_timeout_%0d", i), 0, 1);
        break;
      end
      pll_lock = 1'b0;
      step();
      pll_lock = 1'b1;
      step();
      step();
      if (i == 255) check("loss_at_255", int'(lock_loss_cnt), 255);
    end
    check("loss_saturated", int'(lock_loss_cnt), 255);
`else
    for (int e = 0; e < 5; e++) step();
    check("drop_ignored_ready", int'(ready), 1);
    check("drop_ignored_tmds_oe", int'(tmds_oe), 1);
    check("loss_tied_zero", int'(lock_loss_cnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
